// File: rtl/sdp_wr_burst_port_if.sv
// Valid/ready channel carrying one W-bit word per transfer.
// master drives valid/data and samples ready; slave samples valid/data and drives ready.
// A transfer happens on any cycle where valid and ready are both high.
interface sdp_wr_burst_port_if #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sdp_wr_burst_port.sv
// Write-side burst port for the simple dual-port memory: takes {len, base} on cmd_if,
// writes len+1 words from data_if to consecutive addresses, then returns the last
// written address on done_if. Ports: clk/rst, cmd_if/data_if (slave), done_if (master),
// en_o/addr_o/data_o (memory write port, combinational from data_if in BURST).
// Latency: one word per cycle in BURST; done_if.valid rises 1 cycle after the last write.
module sdp_wr_burst_port #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 16,
  parameter int W_LEN  = 8
) (
  input  logic                clk,
  input  logic                rst,
  sdp_wr_burst_port_if.slave  cmd_if,
  sdp_wr_burst_port_if.slave  data_if,
  sdp_wr_burst_port_if.master done_if,
  output logic                en_o,
  output logic [W_ADDR-1:0]   addr_o,
  output logic [W_DATA-1:0]   data_o
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            state, state_nxt;
  logic [W_ADDR-1:0] addr_reg;
  logic [W_LEN-1:0]  cnt_reg;
  logic [W_ADDR-1:0] last_reg;

  logic cmd_xfer, data_xfer, done_xfer;

  assign cmd_xfer  = cmd_if.valid  & cmd_if.ready;
  assign data_xfer = data_if.valid & data_if.ready;
  assign done_xfer = done_if.valid & done_if.ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_xfer) state_nxt = BURST;
      BURST:   if (data_xfer && cnt_reg == '0) state_nxt = DONE;
      DONE:    if (done_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend on state only (plus data_if.valid for the write strobe), so
  // no ready has a combinational path from any valid. Everything is forced
  // quiet while rst is high, even though the state register clears a cycle later.
  always_comb begin
    cmd_if.ready  = 1'b0;
    data_if.ready = 1'b0;
    done_if.valid = 1'b0;
    en_o          = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:  cmd_if.ready = 1'b1;
        BURST: begin
          data_if.ready = 1'b1;
          en_o          = data_if.valid;
        end
        DONE:  done_if.valid = 1'b1;
        default: ;
      endcase
    end
  end

  assign addr_o       = addr_reg;
  assign data_o       = data_if.data;
  assign done_if.data = last_reg;

  // Datapath. cnt_reg counts remaining words minus one, so the final word is
  // the one seen with cnt_reg==0 and the counter never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
      cnt_reg  <= '0;
      last_reg <= '0;
    end else begin
      if (state == IDLE && cmd_xfer) begin
        addr_reg <= cmd_if.data[W_ADDR-1:0];
        cnt_reg  <= cmd_if.data[W_ADDR+W_LEN-1:W_ADDR];
      end else if (state == BURST && data_xfer) begin
        addr_reg <= addr_reg + 1'b1;  // wraps modulo 2^W_ADDR
        if (cnt_reg == '0) last_reg <= addr_reg;
        else               cnt_reg  <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdp_wr_burst_port.sv
module tb_sdp_wr_burst_port;
  localparam int W_DATA = 16;
  localparam int W_ADDR = 16;
  localparam int W_LEN  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdp_wr_burst_port_if #(.W(W_LEN+W_ADDR)) cmd_if ();
  sdp_wr_burst_port_if #(.W(W_DATA))       data_if ();
  sdp_wr_burst_port_if #(.W(W_ADDR))       done_if ();

  logic              en_o;
  logic [W_ADDR-1:0] addr_o;
  logic [W_DATA-1:0] data_o;

  sdp_wr_burst_port #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .W_LEN(W_LEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .cmd_if  (cmd_if),
    .data_if (data_if),
    .done_if (done_if),
    .en_o    (en_o),
    .addr_o  (addr_o),
    .data_o  (data_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Monitor: inputs change just after posedge, so the negedge sees the values
  // that the next posedge will act on.
  int          cyc = 0;
  logic [15:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];
  logic [15:0] dd[$];
  int          dc[$];
  int          cc[$];
  logic        busy = 1'b0;
  int          busy_rdy = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (en_o) begin
      wa.push_back(addr_o);
      wd.push_back(data_o);
      wc.push_back(cyc);
    end
    if (done_if.valid && done_if.ready) begin
      dd.push_back(done_if.data);
      dc.push_back(cyc);
      busy <= 1'b0;
    end
    if (cmd_if.valid && cmd_if.ready) begin
      cc.push_back(cyc);
      busy <= 1'b1;
    end
    if (busy && cmd_if.ready) busy_rdy <= busy_rdy + 1;
  end

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete();
    dd.delete(); dc.delete(); cc.delete();
  endtask

  task automatic send_cmd(input logic [15:0] base, input logic [7:0] len);
    int   n = 0;
    logic ok = 1'b0;
    cmd_if.valid = 1'b1;
    cmd_if.data  = {len, base};
    while (n < 2000) begin
      @(negedge clk);
      if (cmd_if.ready) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) chk("cmd_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    cmd_if.valid = 1'b0;
  endtask

  task automatic send_data(input logic [15:0] d, input int gap);
    int   n = 0;
    logic ok = 1'b0;
    data_if.valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    data_if.valid = 1'b1;
    data_if.data  = d;
    while (n < 2000) begin
      @(negedge clk);
      if (data_if.ready) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) chk("data_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    data_if.valid = 1'b0;
  endtask

  task automatic wait_tokens(input int n_exp);
    int n = 0;
    while (dd.size() < n_exp && n < 600) begin
      @(posedge clk);
      n++;
    end
    if (dd.size() < n_exp) chk("done_timeout", dd.size(), n_exp);
    #1;
  endtask

  initial begin
    cmd_if.valid  = 1'b0;
    cmd_if.data   = '0;
    data_if.valid = 1'b0;
    data_if.data  = '0;
    done_if.ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_rdy", cmd_if.ready, 0);
    chk("rst_data_rdy", data_if.ready, 0);
    chk("rst_done_vld", done_if.valid, 0);
    chk("rst_en", en_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_rdy", cmd_if.ready, 1);

    // Single word; data offered in IDLE first must not be consumed early
    @(posedge clk); #1;
    data_if.valid = 1'b1;
    data_if.data  = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("idle_data_rdy", data_if.ready, 0);
      chk("idle_en", en_o, 0);
    end
    @(posedge clk); #1;
    fork
      send_cmd(16'h0010, 8'd0);
      send_data(16'hBEEF, 0);
    join
    wait_tokens(1);
    chk("t1_nwr", wa.size(), 1);
    chk("t1_addr", wa[0], 16'h0010);
    chk("t1_data", wd[0], 16'hBEEF);
    chk("t1_done", dd[0], 16'h0010);
    chk("t1_lat", dc[0] - wc[0], 1);
    clear_logs();

    // Streaming burst
    fork
      send_cmd(16'h0100, 8'd3);
      for (int i = 0; i < 4; i++) send_data(16'h00A0 + 16'(i), 0);
    join
    wait_tokens(1);
    chk("t2_nwr", wa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", wa[i], 16'h0100 + 16'(i));
      chk("t2_data", wd[i], 16'h00A0 + 16'(i));
      chk("t2_cyc", wc[i] - wc[0], i);
    end
    chk("t2_done", dd[0], 16'h0103);
    chk("t2_span", dc[0] - cc[0], 5);
    clear_logs();

    // Stalls and done backpressure
    done_if.ready = 1'b0;
    busy_rdy = 0;
    fork
      send_cmd(16'h0020, 8'd2);
      for (int i = 0; i < 3; i++) send_data(16'h0C00 + 16'(i), (i == 0) ? 0 : 2);
    join
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_vld", done_if.valid, 1);
      chk("t3_hold_dat", done_if.data, 16'h0022);
      chk("t3_hold_cmd", cmd_if.ready, 0);
    end
    @(posedge clk); #1;
    done_if.ready = 1'b1;
    wait_tokens(1);
    chk("t3_nwr", wa.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_addr", wa[i], 16'h0020 + 16'(i));
    chk("t3_gap", wc[1] - wc[0], 3);
    chk("t3_done", dd[0], 16'h0022);
    chk("t3_cmd_rdy_busy", busy_rdy, 0);
    clear_logs();

    // Address wrap
    fork
      send_cmd(16'hFFFE, 8'd3);
      for (int i = 0; i < 4; i++) send_data(16'h1100 + 16'(i), 0);
    join
    wait_tokens(1);
    chk("t4_nwr", wa.size(), 4);
    chk("t4_a0", wa[0], 16'hFFFE);
    chk("t4_a1", wa[1], 16'hFFFF);
    chk("t4_a2", wa[2], 16'h0000);
    chk("t4_a3", wa[3], 16'h0001);
    chk("t4_done", dd[0], 16'h0001);
    clear_logs();

    // Maximum length
    fork
      send_cmd(16'h1000, 8'd255);
      for (int i = 0; i < 256; i++) send_data(16'(i) ^ 16'h5A5A, 0);
    join
    wait_tokens(1);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_nwr", wa.size(), 256);
    for (int i = 0; i < 256 && i < wa.size(); i++) begin
      chk("t5_addr", wa[i], 16'h1000 + 16'(i));
      chk("t5_data", wd[i], 16'(i) ^ 16'h5A5A);
    end
    chk("t5_ntok", dd.size(), 1);
    chk("t5_done", dd[0], 16'h10FF);
    clear_logs();

    // Reset mid-burst
    fork
      send_cmd(16'h0040, 8'd7);
      for (int i = 0; i < 3; i++) send_data(16'h4000 + 16'(i), 0);
    join
    data_if.valid = 1'b1;
    data_if.data  = 16'h4003;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_en", en_o, 0);
    chk("t6_rst_drdy", data_if.ready, 0);
    chk("t6_rst_crdy", cmd_if.ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    data_if.valid = 1'b0;
    @(negedge clk);
    chk("t6_idle_crdy", cmd_if.ready, 1);
    repeat (20) @(negedge clk);
    chk("t6_nwr", wa.size(), 3);
    chk("t6_ntok", dd.size(), 0);
    @(posedge clk); #1;
    clear_logs();
    fork
      send_cmd(16'h0050, 8'd0);
      send_data(16'h5555, 0);
    join
    wait_tokens(1);
    chk("t6b_nwr", wa.size(), 1);
    chk("t6b_addr", wa[0], 16'h0050);
    chk("t6b_data", wd[0], 16'h5555);
    chk("t6b_done", dd[0], 16'h0050);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdp_wr_burst_port.md
Name: sdp_wr_burst_port

Overview:
Write-side port for the simple dual-port memory. It accepts a burst command carrying a base address and a length over a dti consumer interface. It then writes the matching words from a data stream into consecutive memory addresses, at one word per cycle. When a burst finishes, it reports completion over a dti producer interface so upstream logic can order later reads after the writes.

Parameters:
W_DATA, 16, width of a memory word and of data_if.data
W_ADDR, 16, memory address width
W_LEN, 8, width of the burst length field; the burst writes len+1 words

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
cmd_if  dti.consumer  W_LEN+W_ADDR  burst command; [W_ADDR-1:0] = base address, [W_ADDR+W_LEN-1:W_ADDR] = len
data_if  dti.consumer  W_DATA  write data words, in address order
done_if  dti.producer  W_ADDR  completion token; data = last address written
en_o  output  1  memory write enable, one word per cycle
addr_o  output  W_ADDR  memory write address
data_o  output  W_DATA  memory write data

Behaviour:
- dti rules:
  - A transfer occurs on a cycle where valid & ready are both 1.
  - A producer holds valid and data stable until the transfer.
  - done_if.valid does not depend on done_if.ready.
  - cmd_if.ready and data_if.ready are functions of state only, with no combinational path from any input valid.
- State registers:
  - state ∈ {IDLE, BURST, DONE}
  - addr_reg (W_ADDR bits)
  - cnt_reg (W_LEN bits)
  - last_reg (W_ADDR bits)
- Reset:
  - state=IDLE; addr_reg, cnt_reg, last_reg = 0.
  - While rst=1: cmd_if.ready=0, data_if.ready=0, done_if.valid=0, en_o=0.
- IDLE:
  - Outputs: cmd_if.ready=1, data_if.ready=0, en_o=0.
  - On cmd transfer: addr_reg <= base, cnt_reg <= len, state <= BURST.
- BURST:
  - Outputs: data_if.ready=1, cmd_if.ready=0.
  - en_o = data_if.valid. addr_o = addr_reg. data_o = data_if.data (combinational; the memory samples on the same clk edge).
  - On data transfer:
    - addr_reg <= addr_reg+1, wrapping modulo 2^W_ADDR (0xFFFF+1 -> 0x0000 at default).
    - If cnt_reg==0: last_reg <= addr_reg, state <= DONE.
    - Otherwise: cnt_reg <= cnt_reg-1.
  - A data_if.valid=0 cycle stalls the burst with no write.
  - Throughput: one word per cycle when data_if.valid is held high.
- DONE:
  - Outputs: done_if.valid=1, done_if.data=last_reg; cmd_if.ready=0, data_if.ready=0, en_o=0.
  - On done transfer: state <= IDLE.
  - If done_if.ready is low, the port holds in DONE indefinitely.
- Timing:
  - Minimum command-to-command spacing is len+1+2 cycles with no backpressure: one IDLE accept cycle, len+1 BURST cycles, one DONE cycle.
  - Latency from the last data transfer to done_if.valid is 1 cycle.
- Boundary conditions:
  - len=0: a single-word burst; done_if.data = base.
  - len = 2^W_LEN-1: writes 2^W_LEN words; cnt_reg never underflows.
  - Address wrap within a burst is legal; last_reg reflects the wrapped address.
  - data_if.valid high in IDLE or DONE: not consumed, no write.
  - cmd_if.valid high in BURST or DONE: not accepted until the next IDLE.
  - Reset asserted mid-burst: the burst is abandoned and no done token is produced. Words already written remain in memory. State returns to IDLE on the cycle after rst samples 1.
- Out of scope: no byte enables and no read-during-write checks; arbitration with the read port belongs to the memory.

Test Plan:
- Single word: cmd base=0x0010, len=0; data 0xBEEF -> one en_o pulse with addr_o=0x0010, data_o=0xBEEF; done_if.data=0x0010 one cycle later.
- Streaming burst: cmd base=0x0100, len=3; data 0xA0..0xA3 back-to-back -> en_o high for 4 consecutive cycles at addr 0x0100..0x0103; done=0x0103; total 6 cycles from cmd accept to done accept.
- Stalls and backpressure: base=0x0020, len=2, with data_if.valid gaps of 2 cycles between words and done_if.ready held low for 5 cycles -> exactly 3 writes at 0x20..0x22; done_if.valid stays high and stable with data 0x0022 until ready; cmd_if.ready=0 throughout.
- Address wrap: base=0xFFFE, len=3 -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001; done=0x0001.
- Max length: len=255 -> exactly 256 writes at base..base+255 and one done token; no extra en_o pulse.
- Reset mid-burst: base=0x0040, len=7; assert rst after 3 words -> no further en_o and no done token; next cmd base=0x0050, len=0 is accepted in IDLE and completes normally.
